// File: rtl/nibble_add_sequencer.sv
// Sequences a WIDTH-bit add through an external 4-bit ripple-carry slice, LSB nibble first.
// Optional subtract support via `define NIBBLE_ADD_SUB_EN (adds the 1-bit op input).
module nibble_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

  logic             accept_s;
  logic             last_s;
  logic [IW+1:0]    bit_ofs_s;
  logic [WIDTH-1:0] b_lat_s;
  logic             cin_lat_s;

  assign accept_s  = (state_q == S_IDLE) && in_valid && in_ready_q;
  assign last_s    = (idx_q == IDX_LAST);
  assign bit_ofs_s = {idx_q, 2'b00};

  // Subtraction is folded in at latch time: store ~B and force the initial carry to 1.
`ifdef NIBBLE_ADD_SUB_EN
  assign b_lat_s   = op ? ~b : b;
  assign cin_lat_s = op ? 1'b1 : cin;
`else
  assign b_lat_s   = b;
  assign cin_lat_s = cin;
`endif

  // Drive the shared adder slice only while stepping through nibbles.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_q == S_RUN) begin
      add_a   = a_q[bit_ofs_s +: 4];
      add_b   = b_q[bit_ofs_s +: 4];
      add_cin = carry_q;
    end else begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_s) state_d = S_RUN;  else state_d = S_IDLE;
      S_RUN:  if (last_s)   state_d = S_DONE; else state_d = S_RUN;
      S_DONE: if (out_ready) state_d = S_IDLE; else state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: operand latch, per-nibble sum capture, carry chaining.
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          a_d     = a;
          b_d     = b_lat_s;
          carry_d = cin_lat_s;
          idx_d   = '0;
        end else begin
          a_d = a_q;
        end
      end
      S_RUN: begin
        sum_d[bit_ofs_s +: 4] = add_s;
        carry_d               = add_cout;
        if (last_s) begin
          idx_d  = '0;
          cout_d = add_cout;
          ovf_d  = (add_a[3] == add_b[3]) && (add_s[3] != add_a[3]);
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        idx_d = idx_q;
      end
      default: begin
        idx_d = '0;
      end
    endcase
  end

  assign out_valid_d = (state_d == S_DONE);
  assign busy_d      = (state_d != S_IDLE);
  assign in_ready_d  = (state_d == S_IDLE);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed self-checking bench for nibble_add_sequencer (WIDTH=16) with a behavioural 4-bit slice.
module tb_nibble_add_sequencer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_s;
  logic             add_cout;

  int cmp_cnt = 0;
  int err_cnt = 0;

  nibble_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef NIBBLE_ADD_SUB_EN
    .op       (op),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .busy     (busy),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  always #5 clk = ~clk;

  // External ripple-carry slice.
  assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic [15:0] es, input logic ec, input logic eo,
                        input bit junk, output logic [3:0] cseq);
    int cyc;
    check_eq({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    if (junk) begin
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    cyc  = 0;
    cseq = 4'h0;
    while (!out_valid && cyc < 20) begin
      if (cyc < 4) cseq[cyc] = add_cin;
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, ".latency"}, 32'(cyc), 32'd4);
    check_eq({tag, ".sum"}, 32'(sum), 32'(es));
    check_eq({tag, ".cout"}, 32'(cout), 32'(ec));
    check_eq({tag, ".ovf"}, 32'(ovf), 32'(eo));
    check_eq({tag, ".busy"}, 32'(busy), 32'd1);
    check_eq({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
  endtask

  task automatic handshake(input string tag, input logic [15:0] es);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, ".ov_clr"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".busy_clr"}, 32'(busy), 32'd0);
    check_eq({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
    check_eq({tag, ".sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
    out_ready = 1'b0; op = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.in_ready", 32'(in_ready), 32'd0);
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.sum", 32'(sum), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst.in_ready", 32'(in_ready), 32'd1);
    check_eq("idle.add_a", 32'(add_a), 32'd0);

    // 4+D carries, so every later nibble sees carry-in 1.
    run_op("add1", 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0, seq);
    check_eq("add1.cin_seq", 32'(seq), 32'(4'b1110));
    handshake("add1", 16'h2221);

    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, seq);
    handshake("wrap", 16'h0000);
    run_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, seq);
    handshake("posovf", 16'h8000);
    run_op("cin1", 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, seq);
    check_eq("cin1.cin_seq", 32'(seq), 32'(4'b0011));
    handshake("cin1", 16'h0010);
    run_op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, seq);
    handshake("negovf", 16'h0000);

    // Reset after two RUN cycles aborts the operation.
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort.out_valid", 32'(out_valid), 32'd0);
    check_eq("abort.sum", 32'(sum), 32'd0);
    check_eq("abort.busy", 32'(busy), 32'd0);
    check_eq("abort.cout", 32'(cout), 32'd0);
    check_eq("abort.ovf", 32'(ovf), 32'd0);
    check_eq("abort.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort.no_valid", 32'(out_valid), 32'd0);
    run_op("after_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, seq);
    handshake("after_rst", 16'h0003);

    // Backpressure with in_valid held during RUN and DONE.
    run_op("bp", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1, seq);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp.out_valid_hold", 32'(out_valid), 32'd1);
      check_eq("bp.sum_hold", 32'(sum), 32'h0007);
      check_eq("bp.in_ready_low", 32'(in_ready), 32'd0);
    end
    a = 16'h0100; b = 16'h0200; cin = 1'b0;
    handshake("bp", 16'h0007);
    run_op("bp2", 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0, seq);
    handshake("bp2", 16'h0300);

    // Back-to-back with in_valid and out_ready held high.
    a = 16'h0010; b = 16'h0020; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    a = 16'h1000; b = 16'h2000;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("b2b.first_sum", 32'(sum), 32'h0030);
    cyc = 0;
    @(negedge clk);
    cyc++;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("b2b.spacing", 32'(cyc), 32'd6);
    check_eq("b2b.second_sum", 32'(sum), 32'h3000);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("b2b.ov_clr", 32'(out_valid), 32'd0);

`ifdef NIBBLE_ADD_SUB_EN
    op = 1'b1;
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, seq);
    handshake("sub_borrow", 16'hFFFE);
    run_op("sub_ok", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, seq);
    handshake("sub_ok", 16'h0002);
    op = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
